// File: rtl/clock_reset_ctrl.sv
// Sequenced per-channel reset release plus per-channel divided clock enables.
// Optional CLOCK_RESET_CYCLE_CNT_EN adds the run_cycles counter output.
module clock_reset_ctrl #(
  parameter int CH_NUM      = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2,
  parameter int DIV_WIDTH   = 8
) (
  input  logic                        system_clock,
  input  logic                        reset,
  input  logic                        ck_en_in,
  input  logic                        sw_reset_req,
  input  logic [CH_NUM*DIV_WIDTH-1:0] div_ratio,
  output logic [CH_NUM-1:0]           ch_rst_out,
  output logic [CH_NUM-1:0]           ch_clk_en,
  output logic                        seq_done,
  output logic [1:0]                  seq_state
`ifdef CLOCK_RESET_CYCLE_CNT_EN
  ,
  output logic [31:0]                 run_cycles
`endif
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] CH_LAST   = IW'(CH_NUM - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CH_NUM-1:0]   rst_q, rst_d;
  logic                done_q, done_d;
  logic [1:0]          sync_ff;
  logic                synced;

  logic [DIV_WIDTH-1:0] cnt_q   [CH_NUM];
  logic [DIV_WIDTH-1:0] ratio_q [CH_NUM];

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) sync_ff <= '0;
    else       sync_ff <= {sync_ff[0], 1'b1};
  end
  assign synced = sync_ff[1];

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_HOLD;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    done_d  = done_q;
    case (state_q)
      S_HOLD: begin
        if (synced) begin
          if (hold_q == HOLD_LAST) begin
            hold_d   = '0;
            rst_d[0] = 1'b0;
            if (CH_NUM == 1) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_RELEASE;
              idx_d   = IW'(1);
              gap_d   = '0;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      S_RELEASE: begin
        if (gap_q == GAP_LAST) begin
          gap_d        = '0;
          rst_d[idx_q] = 1'b0;
          if (idx_q == CH_LAST) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RUN:   ;
      default: state_d = S_HOLD;
    endcase
    // Applied last so a request overrides a release due on the same edge.
    if (sw_reset_req) begin
      state_d = S_HOLD;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
    end
  end

  // Ratio tracks the input while a channel is held, so the release edge latches it.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      ch_clk_en <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        cnt_q[i]   <= '0;
        ratio_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (rst_q[i] || sw_reset_req) begin
          cnt_q[i]     <= '0;
          ch_clk_en[i] <= 1'b0;
          if (rst_q[i]) ratio_q[i] <= div_ratio[i*DIV_WIDTH +: DIV_WIDTH];
        end else if (!ck_en_in) begin
          ch_clk_en[i] <= 1'b0;
        end else if (cnt_q[i] == ratio_q[i]) begin
          cnt_q[i]     <= '0;
          ch_clk_en[i] <= 1'b1;
          ratio_q[i]   <= div_ratio[i*DIV_WIDTH +: DIV_WIDTH];
        end else begin
          cnt_q[i]     <= cnt_q[i] + 1'b1;
          ch_clk_en[i] <= 1'b0;
        end
      end
    end
  end

`ifdef CLOCK_RESET_CYCLE_CNT_EN
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset)                               run_cycles <= '0;
    else if (sw_reset_req || state_q != S_RUN) run_cycles <= '0;
    else if (run_cycles != '1)               run_cycles <= run_cycles + 1'b1;
  end
`endif

  assign ch_rst_out = rst_q;
  assign seq_done   = done_q;
  assign seq_state  = state_q;

endmodule

// File: tb/tb_clock_reset_ctrl.sv
// Scoreboarded random bench for clock_reset_ctrl against a timeline-based model.
// Honours CLOCK_RESET_CYCLE_CNT_EN to also check run_cycles.
module tb_clock_reset_ctrl;
  localparam int CH = 4;
  localparam int H  = 4;
  localparam int G  = 2;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ck_en;
  logic              sw_req;
  logic [CH*DW-1:0]  div_ratio;
  logic [CH-1:0]     ch_rst_out;
  logic [CH-1:0]     ch_clk_en;
  logic              seq_done;
  logic [1:0]        seq_state;
`ifdef CLOCK_RESET_CYCLE_CNT_EN
  logic [31:0]       run_cycles;
`endif

  clock_reset_ctrl #(.CH_NUM(CH), .HOLD_CYCLES(H), .STAGE_GAP(G), .DIV_WIDTH(DW)) dut (
    .system_clock (clk),
    .reset        (rst),
    .ck_en_in     (ck_en),
    .sw_reset_req (sw_req),
    .div_ratio    (div_ratio),
    .ch_rst_out   (ch_rst_out),
    .ch_clk_en    (ch_clk_en),
    .seq_done     (seq_done),
    .seq_state    (seq_state)
`ifdef CLOCK_RESET_CYCLE_CNT_EN
    ,
    .run_cycles   (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] rst;
    logic [CH-1:0] en;
    logic          done;
    logic [1:0]    state;
    logic [31:0]   rc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;

  // Model: release times are a pure function of the anchor edge; dividers are countdowns.
  int            cyc = 0;
  int            since = 0;
  bit            anchored = 1'b0;
  int            anchor = 0;
  int            remaining [CH];
  logic [CH-1:0] m_rst = '1;
  logic [CH-1:0] m_en = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int ratio_of(input int i);
    logic [DW-1:0] r;
    r = div_ratio[i*DW +: DW];
    return int'(r);
  endfunction

  task automatic model_push();
    exp_t e;
    logic [CH-1:0] new_rst;
    int last;
    cyc++;
    if (rst) begin
      since = 0;
      anchored = 1'b0;
      m_rst = '1;
      m_en = '0;
      for (int i = 0; i < CH; i++) remaining[i] = 0;
    end else begin
      if (since < 3) since++;
      if (since == 2 && !anchored) begin
        anchored = 1'b1;
        anchor = cyc;
      end
      if (sw_req && anchored) anchor = cyc;
      for (int i = 0; i < CH; i++)
        new_rst[i] = !(anchored && cyc >= anchor + H + i*G);
      for (int i = 0; i < CH; i++) begin
        if (sw_req || m_rst[i]) begin
          m_en[i] = 1'b0;
          if (m_rst[i] && !new_rst[i]) remaining[i] = ratio_of(i) + 1;
        end else if (!ck_en) begin
          m_en[i] = 1'b0;
        end else begin
          remaining[i]--;
          if (remaining[i] == 0) begin
            m_en[i] = 1'b1;
            remaining[i] = ratio_of(i) + 1;
          end else begin
            m_en[i] = 1'b0;
          end
        end
      end
      m_rst = new_rst;
    end
    last = anchor + H + (CH-1)*G;
    e.rst = m_rst;
    e.en = m_en;
    if (rst || !anchored || cyc < anchor + H) e.state = 2'd0;
    else if (cyc < last)                      e.state = 2'd1;
    else                                      e.state = 2'd2;
    e.done = (e.state == 2'd2);
    e.rc = (e.state == 2'd2) ? 32'(cyc - last) : 32'd0;
    sb.push_back(e);
  endtask

  // Inputs are set before calling; the expectation is for the next rising edge.
  task automatic tick();
    model_push();
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ch_rst_out", 32'(ch_rst_out), 32'(e.rst));
        check("ch_clk_en", 32'(ch_clk_en), 32'(e.en));
        check("seq_done", 32'(seq_done), 32'(e.done));
        check("seq_state", 32'(seq_state), 32'(e.state));
`ifdef CLOCK_RESET_CYCLE_CNT_EN
        check("run_cycles", run_cycles, e.rc);
`endif
      end
    end
  end

  initial begin
    int ch;
    rst = 1'b1;
    ck_en = 1'b1;
    sw_req = 1'b0;
    div_ratio = '0;
    div_ratio[0*DW +: DW] = 8'd3;
    div_ratio[1*DW +: DW] = 8'd0;
    div_ratio[2*DW +: DW] = 8'd2;
    div_ratio[3*DW +: DW] = 8'd5;
    repeat (10) tick();
    rst = 1'b0;
    repeat (30) tick();

    ck_en = 1'b0;
    repeat (5) tick();
    ck_en = 1'b1;
    repeat (9) tick();

    div_ratio[0*DW +: DW] = 8'd1;
    repeat (12) tick();

    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    repeat (20) tick();

    // Reset lands between edges while the release is still in progress.
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    check("async ch_rst_out", 32'(ch_rst_out), 32'hF);
    check("async ch_clk_en", 32'(ch_clk_en), 32'h0);
    check("async seq_done", 32'(seq_done), 32'h0);
    check("async seq_state", 32'(seq_state), 32'h0);
    repeat (4) tick();
    rst = 1'b0;
    repeat (30) tick();

    repeat (600) begin
      ck_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        ch = int'($urandom_range(0, CH-1));
        div_ratio[ch*DW +: DW] = 8'($urandom_range(0, 6));
      end
      sw_req = anchored && ($urandom_range(0, 79) == 0);
      tick();
    end
    sw_req = 1'b0;
    ck_en = 1'b1;
    repeat (3) tick();
    @(posedge clk);
    #2;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
